// File: rtl/game_timer.sv
// Game-time counter: divides the board clock down to a tick rate and counts
// up toward a limit or down toward zero, with start/pause/resume/clear/preset.
`timescale 1ns/1ps

module game_timer #(
  parameter int CLK_FREQ  = 10000000,
  parameter int TICK_FREQ = 10,
  parameter int CNT_W     = 10
) (
  input  logic             CLOCK10M,
  input  logic             KEY0,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dir,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] counter_out,
  output logic             tick,
  output logic             running,
  output logic             expired,
  output logic [1:0]       state_dbg
);

  // DIV must be an integer >= 2; the prescaler holds 0..DIV-1.
  localparam int DIV   = CLK_FREQ / TICK_FREQ;
  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_step;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               dir_q, dir_d;
  logic               tick_q, tick_d;
  logic               running_q, expired_q;

  // Up mode with limit 0 is free-running and never terminates.
  function automatic logic at_terminal(input logic [CNT_W-1:0] v,
                                       input logic             down,
                                       input logic [CNT_W-1:0] lim);
    if (down) return (v == '0);
    return (lim != '0) && (v == lim);
  endfunction

  assign cnt_step = dir_q ? (cnt_q - 1'b1) : (cnt_q + 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      pre_d   = '0;
      state_d = IDLE;
    end else if (load) begin
      cnt_d   = load_val;
      pre_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dir_d   = dir;
            pre_d   = '0;
            state_d = at_terminal(cnt_q, dir, limit) ? EXPIRED : RUN;
          end
        end
        RUN: begin
          // Pausing freezes the prescaler so sub-tick time survives a pause.
          if (pause) begin
            state_d = PAUSE;
          end else if (pre_q == PRE_MAX) begin
            pre_d  = '0;
            tick_d = 1'b1;
            cnt_d  = cnt_step;
            if (at_terminal(cnt_step, dir_q, limit)) state_d = EXPIRED;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        PAUSE: begin
          if (start) state_d = RUN;
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK10M or posedge KEY0) begin
    if (KEY0) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      dir_q     <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == EXPIRED);
    end
  end

  assign counter_out = cnt_q;
  assign tick        = tick_q;
  assign running     = running_q;
  assign expired     = expired_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with DIV = 10: a single-edge vector table
// plus hand-written multi-cycle sequences with expectations computed here.
`timescale 1ns/1ps

module tb_game_timer;

  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, pause, clear, load, dir;
  logic [CNT_W-1:0] load_val, limit;
  logic [CNT_W-1:0] counter_out;
  logic             tick, running, expired;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  game_timer #(.CLK_FREQ(100), .TICK_FREQ(10), .CNT_W(CNT_W)) dut (
    .CLOCK10M    (clk),
    .KEY0        (rst),
    .start       (start),
    .pause       (pause),
    .clear       (clear),
    .load        (load),
    .load_val    (load_val),
    .dir         (dir),
    .limit       (limit),
    .counter_out (counter_out),
    .tick        (tick),
    .running     (running),
    .expired     (expired),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             start, pause, clear, load, dir;
    logic [CNT_W-1:0] load_val, limit;
    logic [CNT_W-1:0] cnt;
    logic             tk, run, ex;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic s, p, c, l, d,
                              input int lv, lim, ec,
                              input logic et, er, ee);
    vec_t v;
    v.start = s; v.pause = p; v.clear = c; v.load = l; v.dir = d;
    v.load_val = CNT_W'(lv); v.limit = CNT_W'(lim); v.cnt = CNT_W'(ec);
    v.tk = et; v.run = er; v.ex = ee;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [CNT_W-1:0] ec,
                     input logic et, input logic er, input logic ee);
    checks++;
    if (counter_out !== ec || tick !== et || running !== er || expired !== ee) begin
      errors++;
      $display("FAIL %s: got cnt=%0d tick=%b run=%b exp=%b, want cnt=%0d tick=%b run=%b exp=%b",
               name, counter_out, tick, running, expired, ec, et, er, ee);
    end
  endtask

  task automatic quiet();
    start = 0; pause = 0; clear = 0; load = 0;
  endtask

  task automatic do_clear();
    quiet();
    clear = 1;
    step();
    clear = 0;
    chk("clear", 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CNT_W-1:0] ec;
    quiet();
    dir = 0; load_val = 0; limit = 0;
    rst = 1;
    step();
    chk("reset_values", 0, 0, 0, 0);
    rst = 0;

    // Up count to limit 5, then hold in EXPIRED for 100+ cycles.
    limit = 5; dir = 0; start = 1;
    step();
    chk("up_start", 0, 0, 1, 0);
    start = 0;
    for (int i = 1; i <= 160; i++) begin
      step();
      ec = CNT_W'((i / 10 > 5) ? 5 : i / 10);
      chk($sformatf("up_count_%0d", i), ec, (i % 10 == 0) && (i <= 50), i < 50, i >= 50);
    end

    // Pause after the 2nd tick and resume; sub-tick time is preserved.
    do_clear();
    limit = 0; dir = 0; start = 1;
    step();
    chk("pr_start", 0, 0, 1, 0);
    start = 0;
    for (int i = 1; i <= 24; i++) begin
      step();
      chk($sformatf("pr_run_%0d", i), CNT_W'(i / 10), i % 10 == 0, 1, 0);
    end
    pause = 1;
    step();
    chk("pr_pause_enter", 2, 0, 0, 0);
    for (int i = 0; i < 36; i++) begin
      step();
      chk($sformatf("pr_paused_%0d", i), 2, 0, 0, 0);
    end
    pause = 0; start = 1;
    step();
    chk("pr_resume", 2, 0, 1, 0);
    start = 0;
    for (int j = 1; j <= 6; j++) begin
      step();
      if (j < 6) chk($sformatf("pr_after_%0d", j), 2, 0, 1, 0);
      else       chk("pr_third_tick", 3, 1, 1, 0);
    end

    // Down count from a preset of 3; dir is latched only at start.
    do_clear();
    load = 1; load_val = 3;
    step();
    chk("dn_load", 3, 0, 0, 0);
    load = 0; dir = 1; start = 1;
    step();
    chk("dn_start", 3, 0, 1, 0);
    start = 0; dir = 0;
    for (int i = 1; i <= 35; i++) begin
      step();
      ec = CNT_W'(3 - ((i / 10 > 3) ? 3 : i / 10));
      chk($sformatf("dn_count_%0d", i), ec, (i % 10 == 0) && (i <= 30), i < 30, i >= 30);
    end

    // Free-run wrap through 2^CNT_W-1.
    do_clear();
    limit = 0; load = 1; load_val = 1022;
    step();
    chk("wrap_load", 1022, 0, 0, 0);
    load = 0; dir = 0; start = 1;
    step();
    chk("wrap_start", 1022, 0, 1, 0);
    start = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      ec = CNT_W'(1022 + i / 10);
      chk($sformatf("wrap_%0d", i), ec, i % 10 == 0, 1, 0);
    end

    // Asynchronous reset between edges while counting at 4.
    do_clear();
    limit = 0; dir = 0; start = 1;
    step();
    start = 0;
    for (int i = 1; i <= 43; i++) step();
    chk("ar_before", 4, 0, 1, 0);
    #2 rst = 1;
    #1 chk("ar_async", 0, 0, 0, 0);
    step();
    chk("ar_held", 0, 0, 0, 0);
    rst = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      chk($sformatf("ar_idle_%0d", i), 0, 0, 0, 0);
    end

    // Single-edge vectors: priority, simultaneity and immediate expiry.
    //              st pa cl ld dr  lv lim  cnt tk run ex
    vecs[0]  = mk(0, 0, 0, 1, 0,  7, 9,   7, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0,  0, 9,   7, 0, 1, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0,  0, 9,   7, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0,  0, 9,   7, 0, 1, 0);
    vecs[4]  = mk(1, 0, 1, 1, 0,  5, 9,   0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0,  0, 9,   0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 0,  0, 9,   0, 0, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 1,  0, 9,   0, 0, 0, 1);
    vecs[8]  = mk(1, 0, 0, 0, 0,  0, 9,   0, 0, 0, 1);
    vecs[9]  = mk(0, 1, 0, 0, 0,  0, 9,   0, 0, 0, 1);
    vecs[10] = mk(0, 0, 0, 1, 0,  7, 9,   7, 0, 0, 0);
    vecs[11] = mk(1, 0, 0, 0, 0,  0, 7,   7, 0, 0, 1);
    vecs[12] = mk(0, 0, 1, 0, 0,  0, 7,   0, 0, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 0,  0, 0,   0, 0, 1, 0);
    vecs[14] = mk(0, 1, 0, 0, 0,  0, 0,   0, 0, 0, 0);
    vecs[15] = mk(0, 0, 1, 0, 0,  0, 0,   0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      start = vecs[k].start; pause = vecs[k].pause; clear = vecs[k].clear;
      load = vecs[k].load; dir = vecs[k].dir;
      load_val = vecs[k].load_val; limit = vecs[k].limit;
      step();
      chk($sformatf("vec_%0d", k), vecs[k].cnt, vecs[k].tk, vecs[k].run, vecs[k].ex);
    end
    quiet();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Parametrised game-time counter, successor to the fixed 0.1 s up-counter.
- Divides the board clock to a configurable tick rate. Counts up toward a limit or down toward zero, with start, pause, resume, clear and preset.
- Raises an expiry flag at the terminal value.
- Sits between the board clock/keys and the game logic and display decoders.

Parameters:
CLK_FREQ, 10000000, input clock frequency in Hz
TICK_FREQ, 10, count rate in Hz; DIV = CLK_FREQ/TICK_FREQ must be an integer >= 2
CNT_W, 10, width of the time counter

Ports:
CLOCK10M  input  1  system clock, rising-edge
KEY0  input  1  asynchronous active-high reset
start  input  1  level, sampled each cycle; begin/resume counting
pause  input  1  level, sampled each cycle; suspend counting
clear  input  1  synchronous clear to zero and IDLE
load  input  1  synchronous preset to load_val and IDLE
load_val  input  CNT_W  preset value
dir  input  1  0 = count up, 1 = count down; latched on the start that leaves IDLE
limit  input  CNT_W  up-mode terminal value; 0 = free-run, no expiry
counter_out  output  CNT_W  current time value, registered
tick  output  1  one-cycle pulse on each cycle counter_out advances
running  output  1  high in RUN
expired  output  1  high in EXPIRED

Behaviour:
- Clock and reset: one clock, CLOCK10M. KEY0 is asynchronous and active-high. While KEY0 is high, all state is held at reset values.
- Reset values: counter_out = 0, prescaler = 0, state = IDLE, dir_q = 0, tick = 0, running = 0, expired = 0.
- States: IDLE, RUN, PAUSE, EXPIRED. running and expired are registered state decodes.
- Per-cycle priority: clear > load > state transitions > tick advance.
- clear, any state: counter_out <= 0, prescaler <= 0, state <= IDLE.
- load, any state: counter_out <= load_val, prescaler <= 0, state <= IDLE.
- Terminal condition: up mode is counter_out == limit with limit != 0; down mode is counter_out == 0.
- IDLE + start:
  - latch dir_q <= dir and set prescaler <= 0.
  - If the terminal condition already holds (evaluated with dir), go to EXPIRED.
  - Otherwise go to RUN.
  - No tick is issued on this transition.
- RUN + pause: go to PAUSE. The prescaler freezes at its current value. Pause wins if start is also high.
- RUN, no pause:
  - prescaler increments each cycle.
  - When prescaler == DIV-1: prescaler <= 0, tick = 1, counter_out advances by ±1 according to dir_q.
  - If the new value meets the terminal condition, state <= EXPIRED on the same edge.
- PAUSE + start: return to RUN. The prescaler resumes from its frozen value, so elapsed sub-tick time is preserved. dir is not re-latched.
- EXPIRED: counter_out holds and start/pause are ignored. Only clear, load or KEY0 leaves this state.
- Latency: with start sampled at edge k (IDLE to RUN), the first tick and counter change occur at edge k+DIV.
- Wrap-around:
  - Up mode with limit = 0: counter_out wraps from 2^CNT_W-1 to 0 with a normal tick and never expires.
  - Down mode never wraps, because it always expires at 0.
- Up mode with counter_out > limit != 0: counts up through the wrap until it reaches limit.
- tick is low in every cycle except an advance cycle. It is never asserted on clear, load, or a state change without an advance.
- Inputs are synchronous. Debouncing and synchronisation of keys are handled outside this block.
- Width: counter arithmetic is modulo 2^CNT_W. The prescaler is sized to ceil(log2(DIV)) bits.

Test Plan (CLK_FREQ=100, TICK_FREQ=10, so DIV=10; CNT_W=10):
1. Reset and up count: KEY0 pulse, dir=0, limit=5, start at edge 0.
   - Ticks at edges 10, 20, 30, 40, 50; counter_out goes 1..5.
   - expired rises at edge 50, running falls.
   - No further change for 100 cycles.
2. Pause/resume: start, pause 4 cycles after the 2nd tick for 37 cycles, then start.
   - The 3rd tick lands 6 cycles after resume.
   - counter_out is 2 throughout the pause; tick stays low.
3. Down count with preset: load with load_val=3, then dir=1 and start.
   - counter_out goes 2, 1, 0 at +10/+20/+30; expired at the 0 edge.
   - A start with load_val=0 goes to EXPIRED on the next edge with no tick.
4. Free-run wrap: limit=0, load_val=1022, start.
   - counter_out goes 1023, then 0, then 1; tick on each; expired stays 0.
5. Priority and simultaneity:
   - clear+load+start in the same cycle while in RUN: counter_out = 0, IDLE.
   - start+pause in RUN: goes to PAUSE.
   - load in EXPIRED with load_val=7: counter_out = 7, IDLE, expired = 0.
6. Async reset mid-run: assert KEY0 between clock edges at counter_out=4.
   - All outputs reach reset values before the next edge.
   - After release, no ticks until a new start.
